// File: rtl/spike_integrator_pkg.sv
// rtl/spike_integrator_pkg.sv - shared state encoding and saturating arithmetic for the integrator
package spike_integrator_pkg;

  typedef enum logic [1:0] {IDLE, ACCUM, LEAK, EVAL} state_t;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int VMEM_MAX = (2 ** (DEF_DATA_WIDTH - 1)) - 1;
  localparam int VMEM_MIN = -(2 ** (DEF_DATA_WIDTH - 1));

  // Operands arrive sign-extended to int, so the int sum carries the guard bit.
  function automatic int sat_add(input int a, input int b, input int width);
    int hi;
    int lo;
    int sum;
    hi  = (1 << (width - 1)) - 1;
    lo  = -(1 << (width - 1));
    sum = a + b;
    if (sum > hi) return hi;
    if (sum < lo) return lo;
    return sum;
  endfunction

endpackage

// File: rtl/spike_integrator_leak_unit.sv
// rtl/spike_integrator_leak_unit.sv - combinational leak of a membrane potential toward zero
module leak_unit #(
  parameter int DATA_WIDTH = 8
) (
  input  logic signed [DATA_WIDTH-1:0] vmem,
  input  logic signed [DATA_WIDTH-1:0] vleak,
  output logic signed [DATA_WIDTH-1:0] vmem_leaked
);

  logic signed [DATA_WIDTH:0] mag;
  logic signed [DATA_WIDTH:0] diff;

  // A negative leak is meaningless as a magnitude and is treated as no leak.
  always_comb begin
    mag         = vleak[DATA_WIDTH-1] ? '0 : {1'b0, vleak};
    diff        = '0;
    vmem_leaked = vmem;
    if (vmem > 0) begin
      diff        = {vmem[DATA_WIDTH-1], vmem} - mag;
      vmem_leaked = diff[DATA_WIDTH] ? '0 : diff[DATA_WIDTH-1:0];
    end else if (vmem < 0) begin
      diff        = {vmem[DATA_WIDTH-1], vmem} + mag;
      vmem_leaked = (diff > 0) ? '0 : diff[DATA_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/spike_integrator.sv
// rtl/spike_integrator.sv - saturating membrane-potential accumulator with per-step leak and threshold handoff
module spike_integrator
  import spike_integrator_pkg::*;
#(
  parameter int INTEGER_WIDTH   = 8,
  parameter int DATA_WIDTH_FRAC = 0,
  parameter int DATA_WIDTH      = INTEGER_WIDTH + DATA_WIDTH_FRAC,
  parameter int CNT_WIDTH       = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         spikeInValid,
  output logic                         spikeInReady,
  input  logic signed [DATA_WIDTH-1:0] spikeInWeight,
  input  logic                         stepEnd,
  input  logic signed [DATA_WIDTH-1:0] vleak,
  output logic signed [DATA_WIDTH-1:0] vmemToTh,
  output logic                         evalValid,
  input  logic signed [DATA_WIDTH-1:0] vmemFromTh,
  input  logic                         spikeFromTh,
  output logic                         spikeOut,
  output logic                         stepDone,
  output logic [CNT_WIDTH-1:0]         stepEventCount,
  output logic                         stepErr
);

  state_t                       state;
  logic signed [DATA_WIDTH-1:0] vmem;
  logic signed [DATA_WIDTH-1:0] vmem_leaked;
  logic [CNT_WIDTH-1:0]         event_cnt;
  logic                         accept;

  leak_unit #(.DATA_WIDTH(DATA_WIDTH)) u_leak (
    .vmem        (vmem),
    .vleak       (vleak),
    .vmem_leaked (vmem_leaked)
  );

  assign accept = spikeInValid & spikeInReady;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      vmem           <= '0;
      event_cnt      <= '0;
      spikeInReady   <= 1'b0;
      evalValid      <= 1'b0;
      vmemToTh       <= '0;
      spikeOut       <= 1'b0;
      stepDone       <= 1'b0;
      stepEventCount <= '0;
      stepErr        <= 1'b0;
    end else begin
      spikeOut <= 1'b0;
      stepDone <= 1'b0;
      if (stepEnd && state != ACCUM) stepErr <= 1'b1;
      case (state)
        IDLE: begin
          state        <= ACCUM;
          spikeInReady <= 1'b1;
        end
        ACCUM: begin
          // An event in the closing cycle still belongs to the closing step.
          if (accept) begin
            vmem <= DATA_WIDTH'(sat_add(int'(vmem), int'(spikeInWeight), DATA_WIDTH));
            if (event_cnt != '1) event_cnt <= event_cnt + 1'b1;
          end
          if (stepEnd) begin
            state        <= LEAK;
            spikeInReady <= 1'b0;
          end
        end
        LEAK: begin
          vmem      <= vmem_leaked;
          vmemToTh  <= vmem_leaked;
          evalValid <= 1'b1;
          state     <= EVAL;
        end
        EVAL: begin
          vmem           <= vmemFromTh;
          spikeOut       <= spikeFromTh;
          stepDone       <= 1'b1;
          stepEventCount <= event_cnt;
          event_cnt      <= '0;
          evalValid      <= 1'b0;
          vmemToTh       <= '0;
          spikeInReady   <= 1'b1;
          state          <= ACCUM;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
